// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads a combinational instruction memory and queues
// {pc, instr} pairs for decode. Optional perf counters under `FETCH_PERF_EN`.
module fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_instr_i,
  output logic               dec_valid_o,
  input  logic               dec_ready_i,
  output logic [INSTR_W-1:0] dec_instr_o,
  output logic [ADDR_W-1:0]  dec_pc_o,
  input  logic               redirect_valid_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  input  logic               halt_req_i,
  output logic               halted_o,
`ifdef FETCH_PERF_EN
  output logic               fault_o,
  output logic [31:0]        perf_fetched_o,
  output logic [31:0]        perf_stall_o
`else
  output logic               fault_o
`endif
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt, StFault} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [1:0]          count_q, count_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   ent_pc_q    [2];
  logic [INSTR_W-1:0]  ent_instr_q [2];

  logic pop, push, redir_act, redir_ok, halt_act;

  assign pop       = dec_valid_o & dec_ready_i;
  assign redir_act = redirect_valid_i & ((state_q == StRun) | (state_q == StHalt));
  assign redir_ok  = redir_act & (redirect_pc_i[1:0] == 2'b00);
  assign halt_act  = halt_req_i & (state_q == StRun) & ~redir_act;
  // A full queue can still accept a fetch when the head leaves in the same cycle.
  assign push      = (state_q == StRun) & ~redirect_valid_i & ~halt_req_i &
                     ((count_q != 2'd2) | pop);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Entry payload is don't-care while invalid, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      ent_pc_q[wr_ptr_q]    <= pc_q;
      ent_instr_q[wr_ptr_q] <= imem_instr_i;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun: begin
        if (redir_act)       state_d = redir_ok ? StRun : StFault;
        else if (halt_req_i) state_d = StHalt;
      end
      StHalt: begin
        if (redir_act) state_d = redir_ok ? StRun : StFault;
      end
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redir_ok) begin
      pc_d = redirect_pc_i;
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(4);
    end
    if (redir_act) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
    end
  end

  // Outputs
  always_comb begin
    imem_addr_o = pc_q;
    dec_valid_o = (count_q != 2'd0);
    dec_pc_o    = ent_pc_q[rd_ptr_q];
    dec_instr_o = ent_instr_q[rd_ptr_q];
    halted_o    = (state_q == StHalt) && (count_q == 2'd0);
    fault_o     = (state_q == StFault);
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        stall;

  assign stall = (state_q == StRun) & (count_q == 2'd2) & ~pop;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (halt_act) begin
      perf_fetched_d = '0;
      perf_stall_d   = '0;
    end else begin
      if (push && !(&perf_fetched_q)) perf_fetched_d = perf_fetched_q + 32'd1;
      if (stall && !(&perf_stall_q))  perf_stall_d   = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: per-cycle stimulus/expectation table, expected
// outputs queued as each row is driven and compared when the DUT presents them.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;
  logic        redirect_valid, halt_req;
  logic [63:0] redirect_pc;
  logic        halted, fault;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[15:0] ^ 16'hC3A5, a[17:2]};
  endfunction

  assign imem_instr = mem_word(imem_addr);

  fetch_ctrl #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(64'h0)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .imem_addr_o      (imem_addr),
    .imem_instr_i     (imem_instr),
    .dec_valid_o      (dec_valid),
    .dec_ready_i      (dec_ready),
    .dec_instr_o      (dec_instr),
    .dec_pc_o         (dec_pc),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .halt_req_i       (halt_req),
    .halted_o         (halted),
`ifdef FETCH_PERF_EN
    .fault_o          (fault),
    .perf_fetched_o   (perf_fetched),
    .perf_stall_o     (perf_stall)
`else
    .fault_o          (fault)
`endif
  );

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [63:0] rpc;
    logic        hlt;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [63:0] e_addr;
    logic        e_halted;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];
  vec_t boot_vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [63:0] rpc,
                              input logic hlt, input logic ev, input logic [63:0] epc,
                              input logic [63:0] eaddr, input logic eh, input logic ef);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.hlt = hlt;
    v.e_valid = ev; v.e_pc = epc; v.e_addr = eaddr; v.e_halted = eh; v.e_fault = ef;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h, want %h", name, idx, act, exp);
    end
  endtask

  // Outputs depend only on registered state, so the check at negedge sees the
  // result of the previous rising edge.
  task automatic run_row(input vec_t v, input int idx);
    vec_t e;
    dec_ready      = v.rdy;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    halt_req       = v.hlt;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("dec_valid", idx, 64'(dec_valid), 64'(e.e_valid));
    chk("imem_addr", idx, imem_addr, e.e_addr);
    chk("halted", idx, 64'(halted), 64'(e.e_halted));
    chk("fault", idx, 64'(fault), 64'(e.e_fault));
    if (e.e_valid) begin
      chk("dec_pc", idx, dec_pc, e.e_pc);
      chk("dec_instr", idx, 64'(dec_instr), 64'(mem_word(e.e_pc)));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rdy rv rpc                    hlt  ev epc                    addr                h  f
    vecs.push_back(mk(1, 0, 0,                     0,   0, 0,                     0,                 0, 0));
    vecs.push_back(mk(1, 0, 0,                     0,   0, 0,                     0,                 0, 0));
    vecs.push_back(mk(1, 0, 0,                     0,   1, 0,                     'h4,               0, 0));
    vecs.push_back(mk(1, 0, 0,                     0,   1, 'h4,                   'h8,               0, 0));
    vecs.push_back(mk(1, 0, 0,                     0,   1, 'h8,                   'hC,               0, 0));
    vecs.push_back(mk(0, 0, 0,                     0,   1, 'hC,                   'h10,              0, 0));
    vecs.push_back(mk(0, 0, 0,                     0,   1, 'hC,                   'h14,              0, 0));
    vecs.push_back(mk(0, 0, 0,                     0,   1, 'hC,                   'h14,              0, 0));
    vecs.push_back(mk(1, 0, 0,                     0,   1, 'hC,                   'h14,              0, 0));
    vecs.push_back(mk(1, 0, 0,                     0,   1, 'h10,                  'h18,              0, 0));
    vecs.push_back(mk(0, 1, 'h40,                  0,   1, 'h14,                  'h1C,              0, 0));
    vecs.push_back(mk(1, 0, 0,                     0,   0, 0,                     'h40,              0, 0));
    vecs.push_back(mk(1, 0, 0,                     0,   1, 'h40,                  'h44,              0, 0));
    vecs.push_back(mk(0, 0, 0,                     0,   1, 'h44,                  'h48,              0, 0));
    vecs.push_back(mk(0, 0, 0,                     1,   1, 'h44,                  'h4C,              0, 0));
    vecs.push_back(mk(1, 0, 0,                     0,   1, 'h44,                  'h4C,              0, 0));
    vecs.push_back(mk(1, 0, 0,                     0,   1, 'h48,                  'h4C,              0, 0));
    vecs.push_back(mk(1, 0, 0,                     0,   0, 0,                     'h4C,              1, 0));
    vecs.push_back(mk(1, 1, 'h100,                 0,   0, 0,                     'h4C,              1, 0));
    vecs.push_back(mk(1, 0, 0,                     0,   0, 0,                     'h100,             0, 0));
    vecs.push_back(mk(1, 0, 0,                     0,   1, 'h100,                 'h104,             0, 0));
    vecs.push_back(mk(1, 1, 'h200,                 1,   1, 'h104,                 'h108,             0, 0));
    vecs.push_back(mk(1, 0, 0,                     0,   0, 0,                     'h200,             0, 0));
    vecs.push_back(mk(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 'h200,                 'h204,             0, 0));
    vecs.push_back(mk(1, 0, 0,                     0,   0, 0,   64'hFFFF_FFFF_FFFF_FFFC,             0, 0));
    vecs.push_back(mk(1, 0, 0,                     0,   1, 64'hFFFF_FFFF_FFFF_FFFC, 0,               0, 0));
    vecs.push_back(mk(1, 1, 'h22,                  0,   1, 0,                     'h4,               0, 0));
    vecs.push_back(mk(1, 1, 'h300,                 1,   0, 0,                     'h4,               0, 1));
    vecs.push_back(mk(1, 0, 0,                     0,   0, 0,                     'h4,               0, 1));

    // After a mid-run reset: a redirect during BOOT must be ignored.
    boot_vecs.push_back(mk(1, 1, 'h80,             0,   0, 0,                     0,                 0, 0));
    boot_vecs.push_back(mk(1, 0, 0,                0,   0, 0,                     0,                 0, 0));
    boot_vecs.push_back(mk(1, 0, 0,                0,   1, 0,                     'h4,               0, 0));
    boot_vecs.push_back(mk(1, 0, 0,                0,   1, 'h4,                   'h8,               0, 0));

    rst = 1'b1;
    dec_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) run_row(vecs[i], i);

    // Asynchronous reset from the fault state takes effect without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("rst_fault", 100, 64'(fault), 64'(0));
    chk("rst_addr", 100, imem_addr, 64'h0);
    chk("rst_valid", 100, 64'(dec_valid), 64'(0));
    chk("rst_halted", 100, 64'(halted), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (boot_vecs[i]) run_row(boot_vecs[i], 200 + i);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer for the pipelined core. Owns the program counter and drives the word-aligned, combinational-read instruction memory. Buffers fetched {pc, instr} pairs in a 2-entry queue and hands them to decode over a valid/ready handshake. Handles pipeline redirects (branch/jump), halt requests and misaligned-target faults.

Parameters:
ADDR_W, 64, PC / instruction-memory address width (matches data bus width)
INSTR_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_addr  out  ADDR_W  address to instruction memory; always equals pc
imem_instr  in  INSTR_W  instruction word returned combinationally for imem_addr
dec_valid  out  1  head queue entry valid
dec_ready  in  1  decode accepts head entry this cycle
dec_instr  out  INSTR_W  head entry instruction
dec_pc  out  ADDR_W  head entry PC
redirect_valid  in  1  redirect request from execute
redirect_pc  in  ADDR_W  redirect target
halt_req  in  1  stop fetching (pulse or level)
halted  out  1  fetch stopped and queue empty
fault  out  1  sticky misaligned-redirect fault

Behaviour:
- Reset (async, immediate): pc=RESET_PC, state=BOOT, count=0, dec_valid=0, halted=0, fault=0. dec_instr/dec_pc are don't-care while dec_valid=0.
- Queue: 2 entries {pc, instr}, FIFO order. count is 0..2. dec_valid=(count!=0). dec_instr/dec_pc come from the head entry.
- pop = dec_valid & dec_ready. push = fetch condition below. Simultaneous push and pop at any count is legal; count changes by push-pop.
- States:
  - BOOT: lasts exactly one cycle, with no fetch, then goes to RUN.
  - RUN: fetch when (count<2) or (count==2 and pop).
    - Fetch: push {pc, imem_instr}; pc<=pc+4, wrapping modulo 2^ADDR_W.
    - Zero-latency fetch: an instruction fetched at edge N is visible on dec_* after edge N.
    - Steady-state throughput is 1 instr/cycle.
  - HALT: no fetch, pc held, queue drains normally. halted=1 when state==HALT and count==0 (registered-state combinational).
  - FAULT: no fetch, pc held. fault=1 until reset. Queue is flushed on entry.
- Priority within one cycle: redirect > halt_req > fetch.
  - redirect_valid, in RUN or HALT:
    - Queue flushed (count<=0, any pop that cycle is still honoured by decode but the entry is discarded).
    - No push.
    - If redirect_pc[1:0]==0: pc<=redirect_pc, state<=RUN. Redirect therefore also resumes from HALT.
    - Otherwise: state<=FAULT, pc unchanged.
  - halt_req in RUN, no redirect: no push that cycle; state<=HALT.
  - redirect_valid in BOOT: ignored.
  - redirect_valid and halt_req in FAULT: ignored.
- Address width rule: pc[1:0] is always 0. imem_addr is passed whole; the memory drops bits [1:0].
- Reset asserted mid-operation: all state is reinitialised immediately; queued entries are lost.

Optional Feature:
FETCH_PERF_EN
- Defined:
  - Adds outputs perf_fetched (32 bit, pushes counted) and perf_stall (32 bit, RUN cycles with count==2 and no pop).
  - Both counters saturate at 2^32-1 and clear on reset and on halt entry.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=0, dec_ready=1 -> BOOT for 1 cycle, then dec_pc = 0,4,8,12 on consecutive cycles. dec_instr equals the memory word at each address.
- dec_ready=0 from cycle 2 -> count reaches 2, pc stops at 8, imem_addr holds 8. Releasing dec_ready -> entries 0,4,8 issue in order with no gap or duplicate.
- redirect_valid with redirect_pc=0x40 while count==2 -> next cycle dec_valid=0. The cycle after, dec_pc=0x40, then 0x44. Stale entries 0 and 4 never appear.
- halt_req at pc=0x10 with 2 entries queued -> drains 2 entries, then halted=1 and imem_addr stays 0x10. A redirect to 0x100 then gives halted=0 and dec_pc=0x100 two cycles later.
- redirect_pc=0x22 -> fault=1 sticky, dec_valid=0, no further fetch. Reset asserted -> fault=0 and pc=RESET_PC immediately.
- pc=2^ADDR_W-4 via redirect -> next fetched pc wraps to 0. Redirect and halt_req in the same cycle -> redirect wins and state is RUN.
